// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: six-digit time-multiplexed seven-segment driver with per-frame
// input snapshot, anode-off guard interval and blinking encrypted digits.
module ssd_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] num_in1,
  input  logic [3:0] num_in2,
  input  logic [3:0] num_in3,
  input  logic [3:0] num_in4,
  input  logic [3:0] num_in5,
  input  logic [3:0] num_in6,
  input  logic       enc_in1,
  input  logic       enc_in2,
  input  logic       enc_in3,
  input  logic       enc_in4,
  input  logic       enc_in5,
  input  logic       enc_in6,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [15:0][6:0] HEX = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [FW-1:0] r_frame;
  logic          r_blink;
  logic [3:0]    r_sv [6];
  logic          r_se [6];
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    w_num [6];
  logic          w_enc [6];
  logic          w_tick, w_snap, w_e, w_dp;
  logic [3:0]    w_v;
  logic [6:0]    w_hex, w_seg;
  logic [5:0]    w_an;
  assign w_num = '{num_in1, num_in2, num_in3, num_in4, num_in5, num_in6};
  assign w_enc = '{enc_in1, enc_in2, enc_in3, enc_in4, enc_in5, enc_in6};
  assign w_tick = r_cnt == CW'(REFRESH_DIV - 1);
  assign w_snap = w_tick && r_idx == 3'd5;
  assign w_v    = r_sv[r_idx];
  assign w_e    = r_se[r_idx];
  assign w_hex  = HEX[w_v];
  // encrypted F is a blank slot; other encrypted digits alternate glyph+dp and dash
  assign w_seg  = !w_e ? w_hex : w_v == 4'hF ? 7'h7F : r_blink ? 7'h3F : w_hex;
  assign w_dp   = !(w_e && w_v != 4'hF && !r_blink);
  assign w_an   = (enable && r_cnt >= CW'(GUARD)) ? ~(6'd1 << r_idx) : 6'h3F;
  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = w_snap;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_frame <= '0;
      r_blink <= 1'b0;
      r_an    <= 6'h3F;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
      for (int k = 0; k < 6; k++) begin
        r_sv[k] <= 4'hF;
        r_se[k] <= 1'b1;
      end
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_idx <= r_idx == 3'd5 ? 3'd0 : r_idx + 3'd1;
      if (w_snap) begin
        for (int k = 0; k < 6; k++) begin
          r_sv[k] <= w_num[k];
          r_se[k] <= w_enc[k];
        end
        if (r_frame == FW'(BLINK_FRAMES - 1)) begin
          r_frame <= '0;
          r_blink <= ~r_blink;
        end else begin
          r_frame <= r_frame + 1'b1;
        end
      end
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed checks of scan timing, snapshot, glyphs, blink,
// enable gating and asynchronous reset with REFRESH_DIV=8, GUARD=2, BLINK_FRAMES=2.
module tb_ssd_scan_driver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] num_in1 = 4'd1, num_in2 = 4'd2, num_in3 = 4'd3;
  logic [3:0] num_in4 = 4'd4, num_in5 = 4'd5, num_in6 = 4'd6;
  logic       enc_in1 = 1'b0, enc_in2 = 1'b0, enc_in3 = 1'b0;
  logic       enc_in4 = 1'b0, enc_in5 = 1'b0, enc_in6 = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         pe = 0;

  ssd_scan_driver #(.REFRESH_DIV(8), .GUARD(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .num_in1(num_in1), .num_in2(num_in2), .num_in3(num_in3),
    .num_in4(num_in4), .num_in5(num_in5), .num_in6(num_in6),
    .enc_in1(enc_in1), .enc_in2(enc_in2), .enc_in3(enc_in3),
    .enc_in4(enc_in4), .enc_in5(enc_in5), .enc_in6(enc_in6),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance until registered outputs reflect post-reset state cycle s
  task automatic go(input int s);
    while (pe < s + 1) begin
      @(negedge clk);
      pe++;
    end
  endtask

  task automatic view(input string tag, input logic [5:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    chk({tag, ".an"}, {2'b0, an}, {2'b0, e_an});
    chk({tag, ".seg"}, {1'b0, seg}, {1'b0, e_seg});
    chk({tag, ".dp"}, {7'b0, dp}, {7'b0, e_dp});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    view("reset", 6'h3F, 7'h7F, 1'b1);
    chk("reset.fs", {7'b0, frame_start}, 8'h00);
    rst_n = 1'b1;
    pe = 0;
    go(0);   view("f0_s0_guard", 6'h3F, 7'h7F, 1'b1);
    go(2);   view("f0_s0_on", 6'h3E, 7'h7F, 1'b1);
    go(10);  view("f0_s1_on", 6'h3D, 7'h7F, 1'b1);
    go(45);  chk("fs_before", {7'b0, frame_start}, 8'h00);
    go(46);  chk("fs_pulse", {7'b0, frame_start}, 8'h01);
    go(47);  chk("fs_after", {7'b0, frame_start}, 8'h00);
    go(48);  view("f1_s0_guard0", 6'h3F, 7'h79, 1'b1);
    go(49);  view("f1_s0_guard1", 6'h3F, 7'h79, 1'b1);
    go(50);  view("f1_s0_on", 6'h3E, 7'h79, 1'b1);
    go(58);  view("f1_s1", 6'h3D, 7'h24, 1'b1);
    go(60);
    num_in1 = 4'h3; enc_in1 = 1'b1;
    num_in3 = 4'hF; enc_in3 = 1'b1;
    go(66);  view("f1_s2_held", 6'h3B, 7'h30, 1'b1);
    go(90);  view("f1_s5", 6'h1F, 7'h02, 1'b1);
    go(94);  chk("fs2_pulse", {7'b0, frame_start}, 8'h01);
    go(98);  view("f2_s0_dash", 6'h3E, 7'h3F, 1'b1);
    go(114); view("f2_s2_blank", 6'h3B, 7'h7F, 1'b1);
    go(121);
    num_in2 = 4'h9; num_in5 = 4'h7;
    go(130); view("f2_s4_torn", 6'h2F, 7'h12, 1'b1);
    go(146); view("f3_s0_dash", 6'h3E, 7'h3F, 1'b1);
    go(154); view("f3_s1_new", 6'h3D, 7'h10, 1'b1);
    go(178); view("f3_s4_new", 6'h2F, 7'h78, 1'b1);
    go(194); view("f4_s0_glyph", 6'h3E, 7'h30, 1'b0);
    go(225);
    enable = 1'b0;
    go(226); view("en_off0", 6'h3F, 7'h78, 1'b1);
    go(229); view("en_off3", 6'h3F, 7'h78, 1'b1);
    enable = 1'b1;
    go(230); view("en_on_s4", 6'h2F, 7'h78, 1'b1);
    go(234); view("en_on_s5", 6'h1F, 7'h02, 1'b1);
    go(236);
    rst_n = 1'b0;
    #1;
    view("async_rst", 6'h3F, 7'h7F, 1'b1);
    chk("async_rst.fs", {7'b0, frame_start}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pe = 0;
    go(2);   view("rst_restart", 6'h3E, 7'h7F, 1'b1);
    go(10);  view("rst_s1", 6'h3D, 7'h7F, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Downstream consumer of the six-digit display router: takes its six 4-bit digit values and six Encrypt_on flags and drives one shared seven-segment bus plus six digit anodes by time-multiplexing.
- Snapshots all inputs once per scan frame so a frame never mixes old and new values (no tearing).
- Inserts an anode-off guard interval at the start of each slot to suppress ghosting.
- Renders encrypted digits with a blinking marker.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (>= GUARD+2).
- GUARD, 4: cycles at the start of each slot with all anodes off (< REFRESH_DIV).
- BLINK_FRAMES, 32: full frames per blink half-period (>= 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = display on; 0 = all anodes off, scanning continues
- num_in1..num_in6  in  4 each  digit values from the router, slot 0..5
- enc_in1..enc_in6  in  1 each  Encrypt_on flags from the router, slot 0..5
- an  out  6  active-low anodes; an[k] selects slot k
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- dp  out  1  active-low decimal point
- frame_start  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (async, rst_n=0) forces an=6'h3F, seg=7'h7F, dp=1, frame_start=0, slot counter=0, digit index=0, frame counter=0, blink_phase=0. All shadow digits=4'hF with shadow enc=1, so the display shows blank until the first snapshot. Reset may occur mid-slot; outputs go to these values immediately.
- Slot counter: counts 0..REFRESH_DIV-1. tick=1 when it equals REFRESH_DIV-1; the counter then wraps to 0.
- Digit index: advances on tick, 0->1->...->5->0.
- Snapshot: on a tick with index=5, all 12 inputs are captured into shadow registers and frame_start pulses in the same cycle. The new values are used from slot 0 of the next frame. Inputs that change mid-frame are never displayed until the next snapshot.
- Frame counter: advances on each snapshot, counting 0..BLINK_FRAMES-1. On wrap, blink_phase toggles.
- Glyph select, using the shadow value v and shadow enc e for the current index:
  - e=0: standard hex decode, dp=1. Encoding 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
  - e=1, v=F: blank, seg=7F, dp=1.
  - e=1, v!=F, blink_phase=0: hex glyph of v with dp=0.
  - e=1, v!=F, blink_phase=1: dash, seg=3F, dp=1.
- Anode: an[index]=0 only if enable=1 and slot counter >= GUARD; otherwise an=3F. seg and dp are driven regardless of the anode state.
- Latency: an, seg and dp are registered and reflect the counter, index and shadow state of the previous cycle (1-cycle latency).
- Simultaneous events:
  - A snapshot and a blink toggle in the same cycle both take effect.
  - Toggling enable does not reset any counter.
- Width rules:
  - Slot counter width = clog2(REFRESH_DIV); frame counter width = clog2(BLINK_FRAMES).
  - Counters never exceed their terminal value; no arithmetic overflow.

Test Plan:
- Sim parameters: REFRESH_DIV=8, GUARD=2, BLINK_FRAMES=2.
- Reset: hold rst_n=0 -> an=3F, seg=7F, dp=1. Release, with inputs 1..6 and enc=0 -> the first frame stays blank (an pulses per slot, seg=7F); frame_start pulses at cycle 48.
- Normal scan: inputs 1..6, enc=0. After the first snapshot, slot 0: an=3E from its 3rd cycle, seg=79. Slot 1: an=3D, seg=24. Slot 5: an=1F, seg=02. Guard cycles show an=3F.
- Encrypted blank: num_in3=F, enc_in3=1 -> slot 2 has an=3B, seg=7F, dp=1.
- Blink: num_in1=3, enc_in1=1 -> slot 0 shows seg=30, dp=0 for 2 frames, then seg=3F, dp=1 for 2 frames, repeating.
- Tearing: change num_in2 from 2 to 9 during slot 3 -> slot 1 keeps showing seg=24 until the next frame_start, then shows seg=10.
- Enable and reset mid-operation: drop enable during slot 4 -> an=3F while index keeps advancing; raise it -> the correct slot resumes. Then assert rst_n low mid-slot -> outputs go blank asynchronously and the index restarts at 0.
